// File: rtl/control_unit_if.sv
// ============================================================================
//  control_unit_if : bus between control_unit, instruction/data memories and
//                    alu_datapath.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface control_unit_if #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [15:0]           imem_data;
    logic [DATA_WIDTH-1:0] alu_R;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] ir_operand;
    logic [1:0]            cu_A;
    logic [1:0]            cu_B;
    logic [3:0]            opcode;
    logic                  RER;
    logic                  halted;

    modport master (
        input  start, imem_data, alu_R,
        output imem_addr, dmem_addr, dmem_we, ir_operand,
               cu_A, cu_B, opcode, RER, halted
    );

    modport slave (
        output start, imem_data, alu_R,
        input  imem_addr, dmem_addr, dmem_we, ir_operand,
               cu_A, cu_B, opcode, RER, halted
    );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  control_unit : 3-cycle FETCH/DECODE/EXEC sequencer owning PC and IR.
//  Rev 1.0
// ============================================================================
`default_nettype none

module control_unit #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RESET_PC   = 0
) (
    input  wire logic       clk,
    input  wire logic       reset_control_unit,
    control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;
    localparam logic [3:0] OP_JMP = 4'b1011;
    localparam logic [3:0] OP_JZ  = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;

    logic [3:0]          op;
    logic                src;
    logic [1:0]          load_sel;
    logic [PC_WIDTH-1:0] target;
    logic                take_branch;

    logic [1:0]          cu_a;
    logic [1:0]          cu_b;
    logic [3:0]          alu_op;
    logic                rer;
    logic                we;

    // IR[10:8] are reserved and intentionally ignored.
    logic unused_ir_bits;
    assign unused_ir_bits = &{1'b0, ir[10:8]};

    assign op       = ir[15:12];
    assign src      = ir[11];
    assign load_sel = src ? 2'b11 : 2'b10;
    assign target   = PC_WIDTH'(ir[7:0]);

    assign take_branch = (op == OP_JMP) ||
                         ((op == OP_JZ) && (bus.alu_R == '0));

    always_ff @(posedge clk) begin
        if (reset_control_unit) begin
            state <= IDLE;
            pc    <= PC_WIDTH'(RESET_PC);
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH) begin
                ir <= bus.imem_data;
                pc <= pc + 1'b1;
            end else if ((state == EXEC) && take_branch) begin
                pc <= target;
            end
        end
    end

    // Strobes are a pure Moore decode of state+IR, so they are zero outside EXEC.
    always_comb begin
        next_state = state;
        cu_a       = 2'b00;
        cu_b       = 2'b00;
        alu_op     = 4'd0;
        rer        = 1'b0;
        we         = 1'b0;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   next_state = DECODE;
            DECODE:  next_state = EXEC;
            EXEC: begin
                next_state = (op == OP_HLT) ? HALT : FETCH;
                if (!op[3]) begin
                    alu_op = op;
                    rer    = 1'b1;
                end else begin
                    case (op)
                        OP_LDA:  cu_a = load_sel;
                        OP_LDB:  cu_b = load_sel;
                        OP_STR:  we   = 1'b1;
                        default: ;
                    endcase
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = DATA_WIDTH'(ir[7:0]);
    assign bus.ir_operand = DATA_WIDTH'(ir[7:0]);
    assign bus.cu_A       = cu_a;
    assign bus.cu_B       = cu_b;
    assign bus.opcode     = alu_op;
    assign bus.RER        = rer;
    assign bus.dmem_we    = we;
    assign bus.halted     = (state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
//  tb_control_unit : directed + randomized bench with an instruction-level
//                    reference model of control_unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;
    logic clk = 1'b0;
    logic reset_control_unit;
    always #5 clk = ~clk;

    control_unit_if #(.PC_WIDTH(8), .DATA_WIDTH(8)) bus ();

    logic [15:0] imem [256];
    assign bus.imem_data = imem[bus.imem_addr];

    control_unit #(.PC_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(0)) dut (
        .clk                (clk),
        .reset_control_unit (reset_control_unit),
        .bus                (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  m_pc;
    bit          hlt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cu_A, cu_B, opcode, RER, dmem_we, halted}
    function automatic logic [10:0] strobes();
        return {bus.cu_A, bus.cu_B, bus.opcode, bus.RER, bus.dmem_we, bus.halted};
    endfunction

    // What one instruction should show on the strobes during its EXEC cycle.
    function automatic logic [10:0] exp_exec(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] a, b;
        logic [3:0] opc;
        logic       rer, we;
        op = ins[15:12];
        a = 2'b00; b = 2'b00; opc = 4'd0; rer = 1'b0; we = 1'b0;
        if (op < 4'd8) begin
            rer = 1'b1;
            opc = op;
        end else if (op == 4'd8) a = ins[11] ? 2'b11 : 2'b10;
        else if (op == 4'd9)     b = ins[11] ? 2'b11 : 2'b10;
        else if (op == 4'd10)    we = 1'b1;
        return {a, b, opc, rer, we, 1'b0};
    endfunction

    // Runs one instruction from the start of its FETCH cycle.
    task automatic run_instr(input int alu_mode, input bit poke, input bit abort, output bit halted_now);
        logic [15:0] ins;
        logic [7:0]  r;
        chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("fetch_strobes", 32'(strobes()), 32'd0);
        ins  = imem[m_pc];
        m_pc = m_pc + 8'd1;
        if (poke) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("decode_strobes", 32'(strobes()), 32'd0);
        chk("decode_operand", 32'({bus.dmem_addr, bus.ir_operand}), 32'({ins[7:0], ins[7:0]}));
        if (alu_mode < 0) r = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
        else              r = 8'(alu_mode);
        bus.alu_R = r;
        step();
        chk("exec_strobes", 32'(strobes()), 32'(exp_exec(ins)));
        chk("exec_operand", 32'({bus.dmem_addr, bus.ir_operand}), 32'({ins[7:0], ins[7:0]}));
        if (ins[15:12] == 4'd11 || (ins[15:12] == 4'd12 && r == 8'h00)) m_pc = ins[7:0];
        halted_now = (ins[15:12] == 4'd15);
        if (abort) begin
            reset_control_unit = 1'b1;
            step();
            reset_control_unit = 1'b0;
            chk("abort_strobes", 32'(strobes()), 32'd0);
            chk("abort_pc", 32'(bus.imem_addr), 32'd0);
            m_pc       = 8'h00;
            halted_now = 1'b0;
            return;
        end
        if (poke) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (halted_now) begin
            chk("halt_strobes", 32'(strobes()), 32'd1);
            chk("halt_addr", 32'(bus.imem_addr), 32'(m_pc));
        end
    endtask

    task automatic start_prog();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_pc = 8'h00;
    endtask

    task automatic do_reset();
        reset_control_unit = 1'b1;
        bus.start = 1'b1;
        step();
        reset_control_unit = 1'b0;
        bus.start = 1'b0;
        m_pc = 8'h00;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
    endtask

    initial begin
        reset_control_unit = 1'b1;
        bus.start = 1'b1;
        bus.alu_R = 8'h00;
        fill_nop();

        // Reset held with start asserted; afterwards the unit must idle.
        step();
        step();
        chk("reset_strobes", 32'(strobes()), 32'd0);
        chk("reset_addr", 32'(bus.imem_addr), 32'd0);
        reset_control_unit = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("idle_strobes", 32'(strobes()), 32'd0);
        chk("idle_addr", 32'(bus.imem_addr), 32'd0);

        // Immediate loads, ADD, halt.
        imem[0] = 16'h8855;
        imem[1] = 16'h98FE;
        imem[2] = 16'h0000;
        imem[3] = 16'hF000;
        start_prog();
        hlt = 1'b0;
        for (int i = 0; i < 8 && !hlt; i++) run_instr(-1, (i == 1), 1'b0, hlt);
        chk("progA_halted", 32'(hlt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk("halt_hold_strobes", 32'(strobes()), 32'd1);
            chk("halt_hold_addr", 32'(bus.imem_addr), 32'd4);
        end

        // Direct load, store, branches, PC wrap, then reset in EXEC of ADD.
        do_reset();
        fill_nop();
        imem[8'h00] = 16'h8010;
        imem[8'h01] = 16'hA020;
        imem[8'h02] = 16'hC0F0;
        imem[8'hF0] = 16'hC0F5;
        imem[8'hF1] = 16'hB0FD;
        start_prog();
        run_instr(-1, 1'b1, 1'b0, hlt);
        run_instr(-1, 1'b0, 1'b0, hlt);
        run_instr(0,  1'b0, 1'b0, hlt);
        run_instr(1,  1'b1, 1'b0, hlt);
        run_instr(-1, 1'b0, 1'b0, hlt);
        for (int i = 0; i < 3; i++) run_instr(-1, 1'b0, 1'b0, hlt);
        chk("wrap_pc", 32'(m_pc), 32'd0);
        run_instr(-1, 1'b0, 1'b0, hlt);
        imem[8'h01] = 16'h0307;
        run_instr(-1, 1'b0, 1'b1, hlt);
        step();
        chk("post_abort_idle", 32'({strobes(), bus.imem_addr}), 32'd0);

        // Randomized program without HLT.
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'($urandom);
            if (imem[i][15:12] == 4'hF) imem[i][15:12] = 4'hD;
        end
        start_prog();
        for (int i = 0; i < 300; i++)
            run_instr(-1, ($urandom_range(0, 3) == 0), 1'b0, hlt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
